// File: rtl/clock_ratio_monitor_pkg.sv
// Shared types and helpers for the divided-clock period monitor.
// Holds the FSM encoding, the default counter width and the saturation limit helper.
package clock_ratio_monitor_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    localparam int DEF_CNT_W = 16;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/clock_ratio_monitor_sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// The pulse is one clk_i cycle wide and appears 3 cycles after async_i rises.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            edge_q <= sync_q & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures the period of a slow divided clock in CLK_IN cycles and reports it over valid/ready.
// Optional lock tracking is compiled in with `define CLOCK_RATIO_MONITOR_LOCK_EN.
module clock_ratio_monitor
    import clock_ratio_monitor_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXPECTED = 50,
    parameter int TOL      = 1,
    parameter int LOCK_N   = 4
) (
    input  logic             CLK_IN,
    input  logic             n_RST,
    input  logic             SLOW_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    input  logic             PERIOD_READY,
    output logic             IN_TOL,
    output logic             OVERRUN,
    output logic             STALL,
    output logic             LOCKED,
    output state_e           STATE_DBG
);

    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXPECTED);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             in_tol_q;
    logic             overrun_q;
    logic             stall_q;

    logic              edge_w;
    logic signed [CNT_W:0] diff_w;
    logic              in_tol_w;
    logic              meas_edge_w;
    logic              stall_evt_w;

    sync_edge_detect u_sync (
        .clk_i   (CLK_IN),
        .rst_ni  (n_RST),
        .async_i (SLOW_IN),
        .edge_o  (edge_w)
    );

    // One extra bit keeps cnt-EXPECTED from wrapping for any counter value.
    assign diff_w      = $signed({1'b0, cnt_q}) - EXP_S;
    assign in_tol_w    = (diff_w <= TOL_S) && (diff_w >= -TOL_S);
    assign meas_edge_w = (state_q == ST_MEASURE) && edge_w;
    assign stall_evt_w = (state_q == ST_MEASURE) && !edge_w && (cnt_q == CNT_MAX);

    // Handshake: a transfer happens on a rising CLK_IN edge where PERIOD_VALID and
    // PERIOD_READY are both 1; PERIOD/IN_TOL stay stable while VALID=1 and READY=0.
    always_ff @(posedge CLK_IN or negedge n_RST) begin
        if (!n_RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            in_tol_q  <= 1'b0;
            overrun_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            if (valid_q && PERIOD_READY) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (edge_w) begin
                        state_q <= ST_MEASURE;
                        cnt_q   <= CNT_ONE;
                        stall_q <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (edge_w) begin
                        cnt_q <= CNT_ONE;
                        if (!valid_q || PERIOD_READY) begin
                            period_q <= cnt_q;
                            in_tol_q <= in_tol_w;
                            valid_q  <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        stall_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CLOCK_RATIO_MONITOR_LOCK_EN
    localparam int RUN_W = $clog2(LOCK_N + 1);

    logic [RUN_W-1:0] run_q;
    logic             locked_q;

    // Every measured period counts toward lock, including ones dropped by backpressure.
    always_ff @(posedge CLK_IN or negedge n_RST) begin
        if (!n_RST) begin
            run_q    <= '0;
            locked_q <= 1'b0;
        end else if (meas_edge_w) begin
            if (in_tol_w) begin
                if (run_q >= RUN_W'(LOCK_N - 1)) begin
                    locked_q <= 1'b1;
                end
                if (run_q != RUN_W'(LOCK_N)) begin
                    run_q <= run_q + RUN_W'(1);
                end
            end else begin
                run_q    <= '0;
                locked_q <= 1'b0;
            end
        end else if (stall_evt_w) begin
            run_q    <= '0;
            locked_q <= 1'b0;
        end
    end

    assign LOCKED = locked_q;
`else
    assign LOCKED = 1'b0;
`endif

    assign PERIOD       = period_q;
    assign PERIOD_VALID = valid_q;
    assign IN_TOL       = in_tol_q;
    assign OVERRUN      = overrun_q;
    assign STALL        = stall_q;
    assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor (CNT_W=8 so the stall limit is 255 cycles).
// Define CLOCK_RATIO_MONITOR_LOCK_EN for both bench and RTL to exercise lock tracking.
module tb_clock_ratio_monitor;
    import clock_ratio_monitor_pkg::*;

    localparam int W = 8;
`ifdef CLOCK_RATIO_MONITOR_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    logic         CLK_IN = 1'b0;
    logic         n_RST = 1'b0;
    logic         SLOW_IN = 1'b0;
    logic         PERIOD_READY = 1'b0;
    logic [W-1:0] PERIOD;
    logic         PERIOD_VALID;
    logic         IN_TOL;
    logic         OVERRUN;
    logic         STALL;
    logic         LOCKED;
    state_e       STATE_DBG;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [W-1:0] got_p_q[$];
    logic         got_t_q[$];

    clock_ratio_monitor #(.CNT_W(W), .EXPECTED(50), .TOL(1), .LOCK_N(4)) dut (
        .CLK_IN       (CLK_IN),
        .n_RST        (n_RST),
        .SLOW_IN      (SLOW_IN),
        .PERIOD       (PERIOD),
        .PERIOD_VALID (PERIOD_VALID),
        .PERIOD_READY (PERIOD_READY),
        .IN_TOL       (IN_TOL),
        .OVERRUN      (OVERRUN),
        .STALL        (STALL),
        .LOCKED       (LOCKED),
        .STATE_DBG    (STATE_DBG)
    );

    // ---- clock ----
    always #5 CLK_IN = ~CLK_IN;

    // ---- handshake monitor: inputs change at posedge+1, so negedge sees stable values ----
    always @(negedge CLK_IN) begin
        if (n_RST === 1'b1 && PERIOD_VALID === 1'b1 && PERIOD_READY === 1'b1) begin
            got_p_q.push_back(PERIOD);
            got_t_q.push_back(IN_TOL);
        end
    end

    // ---- driver tasks ----
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_IN);
            #1;
        end
    endtask

    task automatic slow_period(input int p);
        SLOW_IN = 1'b1;
        tick(p / 2);
        SLOW_IN = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic apply_reset();
        n_RST = 1'b0;
        SLOW_IN = 1'b0;
        PERIOD_READY = 1'b0;
        tick(3);
        n_RST = 1'b1;
        tick(2);
        got_p_q.delete();
        got_t_q.delete();
    endtask

    // ---- tests ----
    task automatic test_reset();
        n_RST = 1'b0;
        SLOW_IN = 1'b0;
        PERIOD_READY = 1'b0;
        tick(3);
        cmp_cnt++; if (PERIOD !== 8'd0) begin err_cnt++; $display("FAIL rst_period: got %0d want 0", PERIOD); end
        cmp_cnt++; if (PERIOD_VALID !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", PERIOD_VALID); end
        cmp_cnt++; if (IN_TOL !== 1'b0) begin err_cnt++; $display("FAIL rst_in_tol: got %b want 0", IN_TOL); end
        cmp_cnt++; if (OVERRUN !== 1'b0) begin err_cnt++; $display("FAIL rst_overrun: got %b want 0", OVERRUN); end
        cmp_cnt++; if (STALL !== 1'b0) begin err_cnt++; $display("FAIL rst_stall: got %b want 0", STALL); end
        cmp_cnt++; if (LOCKED !== 1'b0) begin err_cnt++; $display("FAIL rst_locked: got %b want 0", LOCKED); end
        cmp_cnt++; if (STATE_DBG !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state: got %0d want %0d", STATE_DBG, ST_IDLE); end
        n_RST = 1'b1;
        tick(2);
    endtask

    task automatic test_nominal();
        apply_reset();
        PERIOD_READY = 1'b1;
        slow_period(50);
        SLOW_IN = 1'b1;
        tick(3);
        cmp_cnt++; if (PERIOD_VALID !== 1'b0) begin err_cnt++; $display("FAIL nom_latency_early: got %b want 0", PERIOD_VALID); end
        tick(1);
        cmp_cnt++; if (PERIOD_VALID !== 1'b1) begin err_cnt++; $display("FAIL nom_valid: got %b want 1", PERIOD_VALID); end
        cmp_cnt++; if (PERIOD !== 8'd50) begin err_cnt++; $display("FAIL nom_period: got %0d want 50", PERIOD); end
        cmp_cnt++; if (IN_TOL !== 1'b1) begin err_cnt++; $display("FAIL nom_in_tol: got %b want 1", IN_TOL); end
        tick(1);
        cmp_cnt++; if (PERIOD_VALID !== 1'b0) begin err_cnt++; $display("FAIL nom_valid_drop: got %b want 0", PERIOD_VALID); end
        tick(20);
        SLOW_IN = 1'b0;
        tick(25);
        repeat (4) slow_period(50);
        cmp_cnt++; if (got_p_q.size() !== 5) begin err_cnt++; $display("FAIL nom_count: got %0d want 5", got_p_q.size()); end
        for (int i = 0; i < got_p_q.size(); i++) begin
            cmp_cnt++; if (got_p_q[i] !== 8'd50 || got_t_q[i] !== 1'b1) begin
                err_cnt++; $display("FAIL nom_capture[%0d]: got %0d/%b want 50/1", i, got_p_q[i], got_t_q[i]);
            end
        end
        cmp_cnt++; if (LOCKED !== LOCK_EN) begin err_cnt++; $display("FAIL nom_locked: got %b want %b", LOCKED, LOCK_EN); end
    endtask

    task automatic test_tolerance();
        int periods[7] = '{52, 52, 49, 49, 51, 48, 48};
        logic [W-1:0] exp_p[6] = '{8'd52, 8'd52, 8'd49, 8'd49, 8'd51, 8'd48};
        logic exp_t[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        PERIOD_READY = 1'b1;
        for (int i = 0; i < 7; i++) slow_period(periods[i]);
        cmp_cnt++; if (got_p_q.size() !== 6) begin err_cnt++; $display("FAIL tol_count: got %0d want 6", got_p_q.size()); end
        for (int i = 0; i < 6 && i < got_p_q.size(); i++) begin
            cmp_cnt++; if (got_p_q[i] !== exp_p[i] || got_t_q[i] !== exp_t[i]) begin
                err_cnt++; $display("FAIL tol_capture[%0d]: got %0d/%b want %0d/%b", i, got_p_q[i], got_t_q[i], exp_p[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_p[3] = '{8'd50, 8'd51, 8'd50};
        apply_reset();
        PERIOD_READY = 1'b0;
        slow_period(50);
        slow_period(53);
        slow_period(50);
        cmp_cnt++; if (PERIOD_VALID !== 1'b1) begin err_cnt++; $display("FAIL bp_valid_held: got %b want 1", PERIOD_VALID); end
        cmp_cnt++; if (PERIOD !== 8'd50) begin err_cnt++; $display("FAIL bp_period_held: got %0d want 50", PERIOD); end
        cmp_cnt++; if (OVERRUN !== 1'b1) begin err_cnt++; $display("FAIL bp_overrun: got %b want 1", OVERRUN); end
        cmp_cnt++; if (got_p_q.size() !== 0) begin err_cnt++; $display("FAIL bp_no_transfer: got %0d want 0", got_p_q.size()); end
        PERIOD_READY = 1'b1;
        tick(1);
        cmp_cnt++; if (PERIOD_VALID !== 1'b0) begin err_cnt++; $display("FAIL bp_release: got %b want 0", PERIOD_VALID); end
        slow_period(50);
        slow_period(50);
        cmp_cnt++; if (got_p_q.size() !== 3) begin err_cnt++; $display("FAIL bp_count: got %0d want 3", got_p_q.size()); end
        for (int i = 0; i < 3 && i < got_p_q.size(); i++) begin
            cmp_cnt++; if (got_p_q[i] !== exp_p[i] || got_t_q[i] !== 1'b1) begin
                err_cnt++; $display("FAIL bp_capture[%0d]: got %0d/%b want %0d/1", i, got_p_q[i], got_t_q[i], exp_p[i]);
            end
        end
        cmp_cnt++; if (OVERRUN !== 1'b1) begin err_cnt++; $display("FAIL bp_overrun_sticky: got %b want 1", OVERRUN); end
    endtask

    task automatic test_stall();
        apply_reset();
        PERIOD_READY = 1'b1;
        slow_period(50);
        tick(208);
        cmp_cnt++; if (STALL !== 1'b0) begin err_cnt++; $display("FAIL stall_early: got %b want 0", STALL); end
        tick(1);
        cmp_cnt++; if (STALL !== 1'b1) begin err_cnt++; $display("FAIL stall_at_255: got %b want 1", STALL); end
        cmp_cnt++; if (PERIOD_VALID !== 1'b0) begin err_cnt++; $display("FAIL stall_valid: got %b want 0", PERIOD_VALID); end
        cmp_cnt++; if (STATE_DBG !== ST_IDLE) begin err_cnt++; $display("FAIL stall_state: got %0d want %0d", STATE_DBG, ST_IDLE); end
        SLOW_IN = 1'b1;
        tick(3);
        cmp_cnt++; if (STALL !== 1'b1) begin err_cnt++; $display("FAIL stall_hold: got %b want 1", STALL); end
        tick(1);
        cmp_cnt++; if (STALL !== 1'b0) begin err_cnt++; $display("FAIL stall_clear: got %b want 0", STALL); end
        tick(21);
        SLOW_IN = 1'b0;
        tick(25);
        cmp_cnt++; if (got_p_q.size() !== 0) begin err_cnt++; $display("FAIL stall_restart_no_capture: got %0d want 0", got_p_q.size()); end
        slow_period(50);
        cmp_cnt++; if (got_p_q.size() !== 1) begin err_cnt++; $display("FAIL stall_resume_count: got %0d want 1", got_p_q.size()); end
        cmp_cnt++; if (PERIOD !== 8'd50) begin err_cnt++; $display("FAIL stall_resume_period: got %0d want 50", PERIOD); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        PERIOD_READY = 1'b0;
        repeat (3) slow_period(50);
        SLOW_IN = 1'b1;
        tick(10);
        cmp_cnt++; if (PERIOD_VALID !== 1'b1 || OVERRUN !== 1'b1) begin
            err_cnt++; $display("FAIL rmid_pre: got valid=%b overrun=%b want 1/1", PERIOD_VALID, OVERRUN);
        end
        n_RST = 1'b0;
        SLOW_IN = 1'b0;
        #1;
        cmp_cnt++; if (PERIOD !== 8'd0) begin err_cnt++; $display("FAIL rmid_period: got %0d want 0", PERIOD); end
        cmp_cnt++; if (PERIOD_VALID !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid: got %b want 0", PERIOD_VALID); end
        cmp_cnt++; if (OVERRUN !== 1'b0 || IN_TOL !== 1'b0 || STALL !== 1'b0 || LOCKED !== 1'b0) begin
            err_cnt++; $display("FAIL rmid_flags: got ovr=%b tol=%b stall=%b lock=%b want 0000", OVERRUN, IN_TOL, STALL, LOCKED);
        end
        tick(2);
        n_RST = 1'b1;
        tick(2);
        got_p_q.delete();
        got_t_q.delete();
        PERIOD_READY = 1'b1;
        slow_period(50);
        cmp_cnt++; if (got_p_q.size() !== 0 || PERIOD_VALID !== 1'b0) begin
            err_cnt++; $display("FAIL rmid_first_edge: got %0d transfers valid=%b want 0/0", got_p_q.size(), PERIOD_VALID);
        end
        slow_period(50);
        cmp_cnt++; if (got_p_q.size() !== 1) begin err_cnt++; $display("FAIL rmid_count: got %0d want 1", got_p_q.size()); end
        cmp_cnt++; if (PERIOD !== 8'd50) begin err_cnt++; $display("FAIL rmid_period2: got %0d want 50", PERIOD); end
    endtask

    task automatic test_lock();
        apply_reset();
        PERIOD_READY = 1'b1;
        repeat (4) slow_period(50);
        cmp_cnt++; if (LOCKED !== 1'b0) begin err_cnt++; $display("FAIL lock_after3: got %b want 0", LOCKED); end
        SLOW_IN = 1'b1;
        tick(4);
        cmp_cnt++; if (LOCKED !== LOCK_EN) begin err_cnt++; $display("FAIL lock_after4: got %b want %b", LOCKED, LOCK_EN); end
        tick(26);
        SLOW_IN = 1'b0;
        tick(30);
        SLOW_IN = 1'b1;
        tick(4);
        cmp_cnt++; if (LOCKED !== 1'b0) begin err_cnt++; $display("FAIL lock_lost: got %b want 0", LOCKED); end
        cmp_cnt++; if (PERIOD !== 8'd60 || IN_TOL !== 1'b0) begin
            err_cnt++; $display("FAIL lock_bad_period: got %0d/%b want 60/0", PERIOD, IN_TOL);
        end
        SLOW_IN = 1'b0;
        tick(10);
    endtask

    // ---- sequence and report ----
    initial begin
        test_reset();
        test_nominal();
        test_tolerance();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
